// File: rtl/pu_mv_sequencer.sv
// Job controller: streams MATRIX_COL column beats from SRAM into the MV PU, then returns its result.
// Optional macro PU_TIMEOUT_EN adds a DONE watchdog that reports RES_ERR.
module pu_mv_sequencer #(
   parameter int WIDTH_OP1   = 16,
   parameter int WIDTH_OP2   = 16,
   parameter int WIDTH_OUT   = 32,
   parameter int MATRIX_ROW  = 8,
   parameter int MATRIX_COL  = 16,
   parameter int MEM_AW      = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                                  clk_i,
   input  logic                                  rstn_i,
   input  logic                                  cmd_valid_i,
   output logic                                  cmd_ready_o,
   input  logic [MEM_AW-1:0]                     cmd_base_i,
   output logic                                  mem_rd_en_o,
   output logic [MEM_AW-1:0]                     mem_addr_o,
   input  logic [WIDTH_OP1-1:0]                  mem_a_i,
   input  logic [MATRIX_ROW-1:0][WIDTH_OP2-1:0]  mem_b_i,
   output logic                                  pu_clr_o,
   output logic                                  pu_start_o,
   output logic                                  pu_vld_o,
   output logic [WIDTH_OP1-1:0]                  pu_a_o,
   output logic [MATRIX_ROW-1:0][WIDTH_OP2-1:0]  pu_b_o,
   input  logic                                  pu_done_i,
   input  logic [MATRIX_ROW-1:0][WIDTH_OUT-1:0]  pu_out_i,
   output logic                                  res_valid_o,
   input  logic                                  res_ready_i,
   output logic [MATRIX_ROW-1:0][WIDTH_OUT-1:0]  res_data_o,
   output logic                                  res_err_o,
   output logic                                  busy_o
);
   localparam int BW = $clog2(MATRIX_COL + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_RESP} state_e;

   state_e                                 state_q, state_d;
   logic [BW-1:0]                          beat_q, beat_d;
   logic [MEM_AW-1:0]                      base_q, base_d;
   logic                                   vld_q, start_q;
   logic [WIDTH_OP1-1:0]                   a_q;
   logic [MATRIX_ROW-1:0][WIDTH_OP2-1:0]   b_q;
   logic [MATRIX_ROW-1:0][WIDTH_OUT-1:0]   res_q, res_d;
   logic                                   rd_en;

`ifdef PU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wcnt_q, wcnt_d;
   logic          err_q, err_d;
   logic          expire;

   assign expire    = (wcnt_q == TW'(TIMEOUT_CYC - 1));
   assign res_err_o = err_q;
`else
   assign res_err_o = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      base_d   = base_q;
      res_d    = res_q;
      rd_en    = 1'b0;
      pu_clr_o = 1'b0;
`ifdef PU_TIMEOUT_EN
      wcnt_d   = wcnt_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               base_d  = cmd_base_i;
               beat_d  = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            pu_clr_o = 1'b1;
            rd_en    = 1'b1;
            beat_d   = BW'(1);
            state_d  = S_STREAM;
         end
         S_STREAM: begin
            // beat_q reaching MATRIX_COL marks the cycle the last beat sits on the PU port
            if (beat_q != BW'(MATRIX_COL)) begin
               rd_en  = 1'b1;
               beat_d = beat_q + 1'b1;
            end else begin
               state_d = S_WAIT;
`ifdef PU_TIMEOUT_EN
               wcnt_d  = '0;
`endif
            end
         end
         S_WAIT: begin
            if (pu_done_i) begin
               res_d   = pu_out_i;
               state_d = S_RESP;
`ifdef PU_TIMEOUT_EN
               err_d   = 1'b0;
            end else if (expire) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               wcnt_d  = wcnt_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            if (res_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         vld_q   <= 1'b0;
         start_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
`ifdef PU_TIMEOUT_EN
         wcnt_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         vld_q   <= rd_en;
         start_q <= (state_q == S_CLEAR);
         res_q   <= res_d;
         if (vld_q) begin
            a_q <= mem_a_i;
            b_q <= mem_b_i;
         end
`ifdef PU_TIMEOUT_EN
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // The SRAM output register is the beat register; the hold copy keeps PU_A/PU_B stable between beats
   assign pu_a_o      = vld_q ? mem_a_i : a_q;
   assign pu_b_o      = vld_q ? mem_b_i : b_q;
   assign pu_vld_o    = vld_q;
   assign pu_start_o  = start_q;
   assign mem_rd_en_o = rd_en;
   assign mem_addr_o  = rd_en ? base_q + MEM_AW'(beat_q) : '0;
   assign cmd_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign res_valid_o = (state_q == S_RESP);
   assign res_data_o  = res_q;

endmodule
